// File: rtl/scan_decoder_pkg.sv
// Shared constants, per-cycle action encoding and the MSB-first one-hot helper for scan_decoder.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest output the helper can build; callers size-cast the result down to their width.
    localparam int unsigned MAX_OUT_W = 64;

    typedef enum logic [1:0] {
        ActOff,
        ActDirect,
        ActHold,
        ActStep
    } action_e;

    function automatic logic [MAX_OUT_W-1:0] onehot_msb(input int unsigned index,
                                                        input int unsigned width);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        if (index < width && width <= MAX_OUT_W) begin
            v = MAX_OUT_W'(1) << (width - 1 - index);
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts enabled cycles and pulses step once count reaches div.
module scan_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] count_q, count_d;

    // >= rather than == so that lowering div below the running count forces an immediate step.
    assign step_o = en_i && !clr_i && (count_q >= div_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = step_o ? '0 : count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with an auto-scan sequencer.
// Define SCAN_DECODER_BLANK_EN to blank the output for one cycle on every scan step (div != 0).
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DIV_W-1:0]    div,
    output logic [2**SEL_W-1:0] out,
    output logic [SEL_W-1:0]    idx,
    output logic                wrap
);

    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] idx_inc;
    logic             scan_en;
    logic             step;
    action_e          act;

    assign scan_en = en && (mode == MODE_SCAN);
    assign idx_inc = idx_q + SEL_W'(1);

    // Count is held at zero outside enabled scan, so each scan entry starts a fresh period.
    scan_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk_i (clk),
        .rst_ni(rst_n),
        .clr_i (!scan_en),
        .en_i  (scan_en),
        .div_i (div),
        .step_o(step)
    );

    always_comb begin
        if (!en) begin
            act = ActOff;
        end else if (mode == MODE_DIRECT) begin
            act = ActDirect;
        end else if (step) begin
            act = ActStep;
        end else begin
            act = ActHold;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        out_d  = '0;
        wrap_d = 1'b0;
        unique case (act)
            ActOff: begin
                // idx keeps its value so scanning can resume where it stopped.
            end
            ActDirect: begin
                idx_d = sel;
                out_d = OUT_W'(onehot_msb(32'(sel), OUT_W));
            end
            ActHold: begin
                out_d = OUT_W'(onehot_msb(32'(idx_q), OUT_W));
            end
            ActStep: begin
                idx_d  = idx_inc;
                wrap_d = (idx_q == {SEL_W{1'b1}});
`ifdef SCAN_DECODER_BLANK_EN
                out_d = (div != '0) ? '0 : OUT_W'(onehot_msb(32'(idx_inc), OUT_W));
`else
                out_d = OUT_W'(onehot_msb(32'(idx_inc), OUT_W));
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: direct-mode vector table plus scan/switching sequences.
module tb_scan_decoder;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned DIV_W = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic [2:0] sel   = '0;
    logic [7:0] div   = '0;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;

    scan_decoder #(
        .SEL_W(SEL_W),
        .DIV_W(DIV_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .sel  (sel),
        .div  (div),
        .out  (out),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        string      tag;
    } exp_t;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    exp_t sb[$];
    vec_t vt[11];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_next(input logic [7:0] o, input logic [2:0] i, input logic w,
                               input string tag);
        exp_t e;
        e.out  = o;
        e.idx  = i;
        e.wrap = w;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare the DUT against the oldest pending expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                failures++;
                $display("FAIL %s: got out=%h idx=%0d wrap=%0b, expected out=%h idx=%0d wrap=%0b",
                         e.tag, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
    endtask

    task automatic drive(input logic e, input logic m, input logic [2:0] s, input logic [7:0] d);
        en   = e;
        mode = m;
        sel  = s;
        div  = d;
    endtask

    // Scan entered from a cleared count at index i0: edge n steps when n is a multiple of d+1.
    task automatic scan_run(input logic [2:0] i0, input logic [7:0] d, input int n0, input int n1,
                            input string tag);
        for (int n = n0; n <= n1; n++) begin
            logic       st;
            logic [2:0] ei;
            logic [7:0] eo;
            st = (n % (int'(d) + 1)) == 0;
            ei = 3'(int'(i0) + n / (int'(d) + 1));
            eo = 8'h80 >> ei;
`ifdef SCAN_DECODER_BLANK_EN
            if (st && d != 8'd0) eo = 8'h00;
`endif
            drive(1'b1, 1'b1, 3'd0, d);
            expect_next(eo, ei, st && (ei == 3'd0), tag);
            tick();
        end
    endtask

    initial begin
        logic [7:0] blank_or_8;
        logic [7:0] blank_or_4;
        blank_or_8 = 8'h08;
        blank_or_4 = 8'h04;
`ifdef SCAN_DECODER_BLANK_EN
        blank_or_8 = 8'h00;
        blank_or_4 = 8'h00;
`endif

        vt[0]  = '{1'b1, 1'b0, 3'd0, 8'h80, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'd1, 8'h40, 3'd1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'd2, 8'h20, 3'd2, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'd3, 8'h10, 3'd3, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'd4, 8'h08, 3'd4, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 3'd5, 8'h04, 3'd5, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 3'd6, 8'h02, 3'd6, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 3'd7, 8'h01, 3'd7, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 3'd3, 8'h00, 3'd7, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 3'd1, 8'h00, 3'd7, 1'b0};
        vt[10] = '{1'b1, 1'b0, 3'd6, 8'h02, 3'd6, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'd4, 8'd0);
        for (int i = 0; i < 2; i++) begin
            expect_next(8'h00, 3'd0, 1'b0, "reset");
            tick();
        end
        rst_n = 1'b1;

        // Direct decode and en=0 hold, table-driven.
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].en, vt[i].mode, vt[i].sel, 8'd0);
            expect_next(vt[i].out, vt[i].idx, vt[i].wrap, $sformatf("vec%0d", i));
            tick();
        end

        // Full sweep at div=2 from idx 0: wrap once at edge 24.
        drive(1'b1, 1'b0, 3'd0, 8'd2);
        expect_next(8'h80, 3'd0, 1'b0, "pre_scan_div2");
        tick();
        scan_run(3'd0, 8'd2, 1, 26, "scan_div2");

        // div=0 steps every edge, wraps every 8.
        drive(1'b1, 1'b0, 3'd0, 8'd0);
        expect_next(8'h80, 3'd0, 1'b0, "pre_scan_div0");
        tick();
        scan_run(3'd0, 8'd0, 1, 17, "scan_div0");

        // Lowering div from 10 to 1 while count=5 forces a step on the next edge.
        drive(1'b1, 1'b0, 3'd3, 8'd10);
        expect_next(8'h10, 3'd3, 1'b0, "pre_scan_div10");
        tick();
        scan_run(3'd3, 8'd10, 1, 5, "scan_div10");
        drive(1'b1, 1'b1, 3'd0, 8'd1);
        expect_next(blank_or_8, 3'd4, 1'b0, "div_drop_step");
        tick();
        expect_next(8'h08, 3'd4, 1'b0, "div_drop_hold");
        tick();
        expect_next(blank_or_4, 3'd5, 1'b0, "div_drop_step2");
        tick();

        // Scan at idx 5, disable (idx holds), resume, then drop to direct sel=2.
        drive(1'b1, 1'b0, 3'd5, 8'd5);
        expect_next(8'h04, 3'd5, 1'b0, "pre_scan_idx5");
        tick();
        scan_run(3'd5, 8'd5, 1, 2, "scan_idx5");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd0, 8'd5);
            expect_next(8'h00, 3'd5, 1'b0, "en_off_hold");
            tick();
        end
        scan_run(3'd5, 8'd5, 1, 7, "scan_resume");
        drive(1'b1, 1'b0, 3'd2, 8'd5);
        expect_next(8'h20, 3'd2, 1'b0, "scan_to_direct");
        tick();

        // Reset lands on what would have been the wrap edge.
        drive(1'b1, 1'b0, 3'd6, 8'd0);
        expect_next(8'h02, 3'd6, 1'b0, "pre_scan_rst");
        tick();
        scan_run(3'd6, 8'd0, 1, 1, "scan_rst");
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 8'd0);
        expect_next(8'h00, 3'd0, 1'b0, "reset_mid_scan");
        tick();
        rst_n = 1'b1;
        scan_run(3'd0, 8'd0, 1, 3, "scan_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
